// File: rtl/weight_ddr_fetch.sv
// Weight fetch engine: reads total_beats words from DDR as a chain of bursts (one outstanding)
// and forwards each returned beat, registered, toward the weight memory.
module weight_ddr_fetch #(
    parameter int DDR_RD_WIDTH = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int BURST_LEN    = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    sys_clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    total_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rd_req_valid,
    input  logic                    rd_req_ready,
    output logic [ADDR_WIDTH-1:0]   rd_req_addr,
    output logic [7:0]              rd_req_len,
    input  logic [DDR_RD_WIDTH-1:0] rd_data_in,
    input  logic                    rd_data_valid_in,
    input  logic                    rd_data_last_in,
    output logic [DDR_RD_WIDTH-1:0] DDR_data_out,
    output logic                    DDR_valid_out
);

    localparam int BYTES_PER_BEAT = DDR_RD_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_FIN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic [8:0]              beat_cnt_q, beat_cnt_d;
    logic [7:0]              len_q, len_d;
    logic                    err_q, err_d;
    logic [DDR_RD_WIDTH-1:0] data_q;
    logic                    valid_q;
    logic [8:0]              burst_beats;

    // beats-1 of the next burst, capped at BURST_LEN
    function automatic logic [7:0] next_len(input logic [CNT_WIDTH-1:0] rem);
        if (rem >= CNT_WIDTH'(BURST_LEN)) return 8'(BURST_LEN - 1);
        return 8'(rem - CNT_WIDTH'(1));
    endfunction

    assign burst_beats = {1'b0, len_q} + 9'd1;

    // NOTE: every _d gets its _q value first so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (total_beats != '0) begin
                        addr_d      = base_addr;
                        remaining_d = total_beats;
                        len_d       = next_len(total_beats);
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_REQ: begin
                if (rd_req_ready) begin
                    beat_cnt_d = burst_beats;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (rd_data_valid_in) begin
                    beat_cnt_d  = beat_cnt_q - 9'd1;
                    remaining_d = (remaining_q != '0) ? remaining_q - CNT_WIDTH'(1) : '0;
                    // last flag is only audited; the counter alone ends the burst
                    if (rd_data_last_in != (beat_cnt_q == 9'd1)) err_d = 1'b1;
                    if (beat_cnt_q == 9'd1) begin
                        addr_d = addr_q + ADDR_WIDTH'(burst_beats) * ADDR_WIDTH'(BYTES_PER_BEAT);
                        if (remaining_q > CNT_WIDTH'(1)) begin
                            len_d   = next_len(remaining_q - CNT_WIDTH'(1));
                            state_d = S_REQ;
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            data_q      <= rd_data_in;
            valid_q     <= rd_data_valid_in && (state_q == S_DATA);
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign err           = err_q;
    assign rd_req_valid  = (state_q == S_REQ);
    assign rd_req_addr   = addr_q;
    assign rd_req_len    = len_q;
    assign DDR_data_out  = data_q;
    assign DDR_valid_out = valid_q;

endmodule
